// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core.
//
// Every rising edge of clk_i the stage does exactly one of three things:
//   - HOLD   : MEM cannot advance, so every register keeps its value.
//   - BUBBLE : the instruction in ID must not enter EX (wrong path after a
//              taken branch, load-use hazard, or ID empty). All outputs go to 0.
//   - LOAD   : the ID instruction moves into EX.
//
// Ports
//   clk_i, rst_i                 clock, async active-low reset
//   ctrl_i[7:0]                  {RegDst, ALUSrc, ALUOp[1:0], MemWrite,
//                                 MemRead, MemtoReg, RegWrite}; [31:8] unused
//   id_valid_i                   ID holds a real instruction
//   rs_data_i, rt_data_i, imm_i  32-bit datapath fields from ID
//   rs_addr_i, rt_addr_i,
//   rd_addr_i, funct_i           register specifiers / funct from ID
//   flush_i                      taken branch, ID is wrong-path
//   mem_busy_i                   MEM back-pressure, freeze the stage
//   *_o                          registered copies presented to EX
//   valid_o                      EX holds a real instruction
//   stall_o                      hold PC and IF/ID (combinational)
//
// Build option
//   ID_EX_PERF_EN  adds stall_cnt_o (load-use stalls taken) and
//                  bubble_cnt_o (bubbles inserted), 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ctrl_i,
    input  logic        id_valid_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [5:0]  funct_i,
    input  logic        flush_i,
    input  logic        mem_busy_i,
    output logic        reg_dst_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic        mem_to_reg_o,
    output logic        reg_write_o,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs_addr_o,
    output logic [4:0]  rt_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [5:0]  funct_o,
    output logic        valid_o,
    output logic        stall_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    logic [7:0]  r_ctrl;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_rd_addr;
    logic [5:0]  r_funct;
    logic        r_valid;

    logic        w_hazard;
    logic        w_bubble;
    logic        w_unused_ctrl;

    // Upper control bits are decoded elsewhere and not carried into EX.
    assign w_unused_ctrl = &{1'b0, ctrl_i[31:8]};

    // Load in EX writing a register that ID reads. Both rs and rt are
    // compared regardless of instruction format; $0 never creates a hazard.
    assign w_hazard = r_valid & r_ctrl[2] & (r_rt_addr != 5'd0) & id_valid_i &
                      ((r_rt_addr == rs_addr_i) | (r_rt_addr == rt_addr_i));

    assign w_bubble = ~mem_busy_i & (flush_i | w_hazard | ~id_valid_i);

    // A flush discards the ID instruction anyway, so it must not be held.
    assign stall_o  = mem_busy_i | (w_hazard & ~flush_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_funct   <= '0;
            r_valid   <= 1'b0;
        end else if (mem_busy_i) begin
            // hold
        end else if (w_bubble) begin
            r_ctrl    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rd_addr <= '0;
            r_funct   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_ctrl    <= ctrl_i[7:0];
            r_rs_data <= rs_data_i;
            r_rt_data <= rt_data_i;
            r_imm     <= imm_i;
            r_rs_addr <= rs_addr_i;
            r_rt_addr <= rt_addr_i;
            r_rd_addr <= rd_addr_i;
            r_funct   <= funct_i;
            r_valid   <= 1'b1;
        end
    end

    assign reg_dst_o    = r_ctrl[7];
    assign alu_src_o    = r_ctrl[6];
    assign alu_op_o     = r_ctrl[5:4];
    assign mem_write_o  = r_ctrl[3];
    assign mem_read_o   = r_ctrl[2];
    assign mem_to_reg_o = r_ctrl[1];
    assign reg_write_o  = r_ctrl[0];
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign rs_addr_o    = r_rs_addr;
    assign rt_addr_o    = r_rt_addr;
    assign rd_addr_o    = r_rd_addr;
    assign funct_o      = r_funct;
    assign valid_o      = r_valid;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_hazard & ~flush_i & ~mem_busy_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
